// File: rtl/mm_out_serializer_pkg.sv
// rtl/mm_out_serializer_pkg.sv - shared constants, FSM states and FIFO entry type for mm_out_serializer
//
// Contents:
//   DATA_W   result width, two's complement
//   LEN_W    width of the length prefix placed in front of every field
//   DEPTH    result buffer entries; one full 8x8 group (2*8-1 results) must fit
//   PTR_W    FIFO pointer width
//   CNT_W    occupancy counter width (0..DEPTH)
//   state_t  serializer FSM states
//   entry_t  FIFO entry: length computed at push time plus the raw result
//   ptr_inc  pointer increment with wrap at DEPTH (DEPTH need not be a power of two)
package mm_pkg;

    localparam int DATA_W = 40;
    localparam int LEN_W  = 6;
    localparam int DEPTH  = 15;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LEN  = 2'd1,
        VAL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/mm_out_serializer_if.sv
// rtl/mm_out_serializer_if.sv - result-in / serial-out signal bundle for mm_out_serializer
//
// Signals:
//   res_valid  upstream result valid
//   res_data   signed result
//   res_last   marks the final result of the group
//   res_ready  serializer accepts a result (handshake = res_valid & res_ready)
//   out_valid  serial output valid, continuous for a whole group
//   out_value  serial output bit, 0 whenever out_valid is 0
// Modports:
//   slave   the serializer
//   master  the upstream producer / downstream consumer side
interface mm_out_serializer_if;
    import mm_pkg::*;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              res_ready;
    logic              out_valid;
    logic              out_value;

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_last,
        output res_ready,
        output out_valid,
        output out_value
    );

    modport master (
        output res_valid,
        output res_data,
        output res_last,
        input  res_ready,
        input  out_valid,
        input  out_value
    );

endinterface

// File: rtl/mm_out_serializer_bitlen_enc.sv
// rtl/mm_out_serializer_bitlen_enc.sv - field length of a signed result (sign check + priority encoder)
//
// Ports:
//   value  in   DATA_W  signed result
//   len    out  LEN_W   number of value bits to emit:
//                       negative -> DATA_W, zero -> 1, positive -> index of top 1 bit + 1
module mm_bitlen_enc
    import mm_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    output logic [LEN_W-1:0]  len
);

    always_comb begin
        len = LEN_W'(1);
        if (value[DATA_W-1]) begin
            len = LEN_W'(DATA_W);
        end else begin
            // Ascending scan: the highest set bit is the last one to assign.
            for (int i = 0; i < DATA_W - 1; i++) begin
                if (value[i]) begin
                    len = LEN_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/mm_out_serializer.sv
// rtl/mm_out_serializer.sv - buffers a group of results and emits them as length-prefixed serial fields
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mm_out_serializer_if (result input handshake + 1-bit serial output)
//
// Operation: results are pushed into a DEPTH-entry FIFO while in FILL. The handshake that
// carries res_last starts the drain: every entry is sent as LEN_W length bits then L value
// bits, both MSB first, with out_valid held high across the whole group. All outputs are
// flops; the first length bit is driven straight from the res_last handshake edge.
module mm_out_serializer
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mm_out_serializer_if.slave bus
);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    state_t             state;
    logic [5:0]         bit_cnt;

    logic               res_ready_q;
    logic               out_valid_q;
    logic               out_value_q;

    logic [LEN_W-1:0]   in_len;
    logic               push;
    entry_t             head;
    logic [PTR_W-1:0]   rd_next;
    logic [LEN_W-1:0]   next_len;
    logic [LEN_W-1:0]   first_len;
    logic [5:0]         cnt_dec;
    logic [2:0]         len_idx;
    logic [5:0]         val_idx;

    mm_bitlen_enc u_enc (
        .value (bus.res_data),
        .len   (in_len)
    );

    // res_ready_q is only ever high in FILL, so a handshake always means FILL.
    assign push      = bus.res_valid & res_ready_q;
    assign head      = mem[rd_ptr];
    assign rd_next   = ptr_inc(rd_ptr);
    assign next_len  = mem[rd_next].len;

    // With an empty FIFO the group's first entry is the one being pushed right now, so its
    // length comes straight from the encoder instead of the (not yet written) buffer.
    assign first_len = (count == '0) ? in_len : head.len;

    assign cnt_dec   = bit_cnt - 1'b1;
    assign len_idx   = cnt_dec[2:0];
    assign val_idx   = head.len - 1'b1;

    assign bus.res_ready = res_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;

    // Buffer storage: contents need no reset, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{len: in_len, data: bus.res_data};
        end
    end

    // bit_cnt holds the index of the bit currently on out_value; the register update
    // presents the next bit so that the serial output is flop-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bit_cnt     <= '0;
            res_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (push) begin
                        wr_ptr <= ptr_inc(wr_ptr);
                        count  <= count + 1'b1;
                        if (bus.res_last) begin
                            state       <= LEN;
                            bit_cnt     <= 6'(LEN_W - 1);
                            res_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_value_q <= first_len[LEN_W-1];
                        end else begin
                            res_ready_q <= ((count + 1'b1) != CNT_W'(DEPTH));
                        end
                    end else begin
                        res_ready_q <= (count != CNT_W'(DEPTH));
                    end
                end

                LEN: begin
                    if (bit_cnt == '0) begin
                        state       <= VAL;
                        bit_cnt     <= val_idx;
                        out_value_q <= head.data[val_idx];
                    end else begin
                        bit_cnt     <= cnt_dec;
                        out_value_q <= head.len[len_idx];
                    end
                end

                VAL: begin
                    if (bit_cnt == '0) begin
                        rd_ptr <= rd_next;
                        count  <= count - 1'b1;
                        if (count > CNT_W'(1)) begin
                            state       <= LEN;
                            bit_cnt     <= 6'(LEN_W - 1);
                            out_value_q <= next_len[LEN_W-1];
                        end else begin
                            state       <= FILL;
                            res_ready_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_value_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt     <= cnt_dec;
                        out_value_q <= head.data[cnt_dec];
                    end
                end

                default: begin
                    state       <= FILL;
                    res_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_value_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_out_serializer.sv
// tb/tb_mm_out_serializer.sv - self-checking bench for mm_out_serializer
module tb_mm_out_serializer;
    import mm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_out_serializer_if bus();

    mm_out_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    bit cap_q[$];
    logic [39:0] pend_q[$];

    function automatic int model_len(input logic [39:0] v);
        int l;
        if (v[39]) return 40;
        if (v == 40'd0) return 1;
        l = 0;
        while ((v >> l) != 40'd0) l++;
        return l;
    endfunction

    // Group is complete: turn the buffered results into the expected bit stream.
    function automatic void model_group();
        foreach (pend_q[n]) begin
            int l;
            logic [5:0] lv;
            l = model_len(pend_q[n]);
            lv = 6'(l);
            for (int k = 5; k >= 0; k--) exp_q.push_back(lv[k]);
            for (int k = l - 1; k >= 0; k--) exp_q.push_back(pend_q[n][k]);
        end
        pend_q.delete();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [39:0] v, input bit last, output int waits, output bit busy);
        bit timed_out;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b1;
        bus.res_data  = v;
        bus.res_last  = last;
        waits = 0;
        timed_out = 1'b0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_ready) break;
            waits++;
            if (waits > 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            check("push_timeout", 64'd1, 64'd0);
        end else begin
            busy = bus.out_valid;
            @(posedge clk);
            pend_q.push_back(v);
            if (last) model_group();
        end
        #1;
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_timeout", 64'(done), 64'd1);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_value", 64'(bus.out_value), 64'd0);
        exp_q.delete();
        pend_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.res_ready), 64'd1);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int w;
        bit b;
        logic [61:0]  v1;
        logic [97:0]  v2;
        logic [97:0]  lit2;
        logic [8:0]   v5;
        logic [63:0]  r;
        logic [39:0]  rv;

        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_last  = 1'b0;

        // Stream checker: every cycle out of reset.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    checks++;
                    if (!bus.out_valid && bus.out_value !== 1'b0) begin
                        failures++;
                        $display("FAIL idle_value actual=%b required=0", bus.out_value);
                    end
                    if (bus.out_valid) begin
                        checks++;
                        if (bus.res_ready !== 1'b0) begin
                            failures++;
                            $display("FAIL ready_while_busy actual=%b required=0", bus.res_ready);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL extra_bit actual=valid required=idle");
                        end else begin
                            bit e;
                            e = exp_q.pop_front();
                            if (bus.out_value !== e) begin
                                failures++;
                                $display("FAIL stream_bit actual=%b required=%b", bus.out_value, e);
                            end
                        end
                        cap_q.push_back(bus.out_value);
                    end else if (exp_q.size() != 0) begin
                        checks++;
                        failures++;
                        $display("FAIL valid_gap actual=0 required=1 pending=%0d", exp_q.size());
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_value", 64'(bus.out_value), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 64'(bus.res_ready), 64'd1);

        // 1: {5, -1, 0 last}
        cap_q.delete();
        push(40'd5, 1'b0, w, b);
        check("t1_wait0", 64'(w), 64'd0);
        push({40{1'b1}}, 1'b0, w, b);
        check("t1_wait1", 64'(w), 64'd0);
        push(40'd0, 1'b1, w, b);
        check("t1_wait2", 64'(w), 64'd0);
        @(negedge clk);
        check("t1_latency", 64'(bus.out_valid), 64'd1);
        wait_idle();
        check("t1_len", 64'(cap_q.size()), 64'd62);
        v1 = '0;
        foreach (cap_q[i]) v1 = {v1[60:0], cap_q[i]};
        check("t1_stream", 64'(v1), 64'({15'b000011101101000, {40{1'b1}}, 7'b0000010}));

        // 2: {2^38, -2^39, 1}
        cap_q.delete();
        push(40'h40_0000_0000, 1'b0, w, b);
        push(40'h80_0000_0000, 1'b0, w, b);
        push(40'd1, 1'b1, w, b);
        wait_idle();
        check("t2_len", 64'(cap_q.size()), 64'd98);
        v2 = '0;
        foreach (cap_q[i]) v2 = {v2[96:0], cap_q[i]};
        lit2 = {6'b100111, 1'b1, 38'd0, 6'b101000, 1'b1, 39'd0, 7'b0000011};
        check("t2_hi", 64'(v2[97:64]), 64'(lit2[97:64]));
        check("t2_lo", v2[63:0], lit2[63:0]);

        // 3: 15 random entries, then a push held until the group has drained
        for (int i = 0; i < 15; i++) begin
            r = {$urandom(), $urandom()};
            rv = r[39:0];
            if (i % 3 == 1) rv = rv >> $urandom_range(0, 39);
            if (i % 7 == 3) rv = 40'd0;
            push(rv, (i == 14), w, b);
            check("t3_ready", 64'(w), 64'd0);
        end
        push(40'd123, 1'b1, w, b);
        check("t3_held", 64'(w > 0), 64'd1);
        check("t3_accept_idle", 64'(b), 64'd0);
        wait_idle();

        // 4: full FIFO without res_last stalls upstream
        for (int i = 0; i < 15; i++) begin
            push(40'(i * 3 + 1), 1'b0, w, b);
            check("t4_fill", 64'(w), 64'd0);
        end
        @(negedge clk);
        check("t4_full_ready", 64'(bus.res_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b1;
        bus.res_data  = 40'd999;
        bus.res_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_stall_ready", 64'(bus.res_ready), 64'd0);
            check("t4_stall_valid", 64'(bus.out_valid), 64'd0);
        end
        async_reset();

        // 5: reset in the middle of a VAL field, then {7}
        push({40{1'b1}}, 1'b1, w, b);
        repeat (12) @(negedge clk);
        check("t5_pre_rst_valid", 64'(bus.out_valid), 64'd1);
        async_reset();
        cap_q.delete();
        push(40'd7, 1'b1, w, b);
        wait_idle();
        check("t5_len", 64'(cap_q.size()), 64'd9);
        v5 = '0;
        foreach (cap_q[i]) v5 = {v5[7:0], cap_q[i]};
        check("t5_stream", 64'(v5), 64'(9'b000011111));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
